// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 key decoder. It holds the
//               prefix and status scan codes, the shift key codes, the
//               key-event record and the prefix FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] c_code_e0 = 8'hE0;  // extended-key prefix
    localparam logic [7:0] c_code_f0 = 8'hF0;  // break (release) prefix
    localparam logic [7:0] c_code_e1 = 8'hE1;  // Pause/Break sequence start

    // Keyboard status and response bytes. These never describe a key.
    localparam logic [7:0] c_code_err0 = 8'h00;
    localparam logic [7:0] c_code_bat  = 8'hAA;
    localparam logic [7:0] c_code_echo = 8'hEE;
    localparam logic [7:0] c_code_ack  = 8'hFA;
    localparam logic [7:0] c_code_rsnd = 8'hFE;
    localparam logic [7:0] c_code_err1 = 8'hFF;

    // Shift keys (both non-extended)
    localparam logic [7:0] c_code_lshift = 8'h12;
    localparam logic [7:0] c_code_rshift = 8'h59;

    // The Pause sequence has 7 bytes after the leading E1
    localparam logic [2:0] c_pause_skip = 3'd7;

    // Key event record. 'release' is a reserved word, so the break flag is
    // stored in the field 'rel'.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } key_event_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_t;

    function automatic logic is_status_code(input logic [7:0] b);
        return (b == c_code_err0) || (b == c_code_bat)  || (b == c_code_echo) ||
               (b == c_code_ack)  || (b == c_code_rsnd) || (b == c_code_err1);
    endfunction

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : Circular key-event FIFO with a valid/ready output side.
//               A push that arrives while the FIFO is full is accepted only
//               when a pop happens in the same cycle.
// Ports       : clock_fpga, reset (async, active-low)
//               push / push_data  - write request and event to store
//               pop_ready         - consumer accepts the head
//               out_valid/out_data- head event (zero when empty)
//               count / full      - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock_fpga,
    input  logic                     reset,
    input  logic                     push,
    input  key_event_t               push_data,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output key_event_t               out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int c_ptr_w = $clog2(DEPTH);

    key_event_t           mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]     count_q,  count_d;
    logic                 pop_ok;
    logic                 push_ok;

    assign full      = (count_q == (c_ptr_w+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    // Head is forced to zero when empty so the outputs read 0 after reset
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        pop_ok   = out_valid & pop_ready;
        // A pop in the same cycle frees a slot for a push into a full FIFO
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (c_ptr_w+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (c_ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule : ps2_event_fifo
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Turns a stream of PS/2 scan-code bytes into key events
//               {code, extended, release}, queues them in a FIFO, and tracks
//               the state of the shift keys.
// Ports       : clock_fpga, reset (async, active-low)
//               code_in/code_valid           - byte stream from PS/2 receiver
//               ev_valid/ev_ready            - event handshake
//               ev_code/ev_ext/ev_release    - head event fields
//               shift_held                   - either non-extended shift down
//               overflow                     - sticky event-dropped flag
//               fifo_count                   - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clock_fpga,
    input  logic                          reset,
    input  logic [7:0]                    code_in,
    input  logic                          code_valid,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_release,
    output logic                          shift_held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int             c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    ps2_state_t           state_q,    state_d;
    logic [2:0]           skip_q,     skip_d;
    logic [c_tmo_w-1:0]   tmo_q,      tmo_d;
    logic                 lshift_q,   lshift_d;
    logic                 rshift_q,   rshift_d;
    logic                 overflow_q, overflow_d;

    logic                 push;
    key_event_t           push_ev;
    key_event_t           head_ev;
    logic                 fifo_full;
    logic                 is_ext;
    logic                 is_brk;

    // ------------------------------------------------------------------
    // Prefix FSM, timeout and shift tracking
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        push     = 1'b0;
        push_ev  = '0;
        is_ext   = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        is_brk   = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

        if (code_valid) begin
            tmo_d = '0;
            if (state_q == ST_SKIP) begin
                // Every byte of the Pause tail is swallowed, status bytes included
                if (skip_q <= 3'd1) begin
                    skip_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    skip_d = skip_q - 3'd1;
                end
            end else if (is_status_code(code_in)) begin
                state_d = ST_IDLE;
            end else if (code_in == c_code_e0) begin
                // E0 after F0 is malformed: drop it and resynchronise
                state_d = (state_q == ST_IDLE || state_q == ST_EXT) ? ST_EXT : ST_IDLE;
            end else if (code_in == c_code_f0) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end
            end else if (code_in == c_code_e1 && state_q == ST_IDLE) begin
                push         = 1'b1;
                push_ev.code = c_code_e1;
                state_d      = ST_SKIP;
                skip_d       = c_pause_skip;
            end else begin
                push         = 1'b1;
                push_ev.code = code_in;
                push_ev.ext  = is_ext;
                push_ev.rel  = is_brk;
                state_d      = ST_IDLE;
                // Shift state follows the decoded event even if the FIFO drops it
                if (!is_ext && code_in == c_code_lshift) begin
                    lshift_d = ~is_brk;
                end
                if (!is_ext && code_in == c_code_rshift) begin
                    rshift_d = ~is_brk;
                end
            end
        end else if (state_q != ST_IDLE) begin
            // Abandon a half-received sequence after TIMEOUT_CYCLES quiet cycles
            if (tmo_q >= c_tmo_last) begin
                tmo_d   = '0;
                skip_d  = '0;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + c_tmo_w'(1);
            end
        end
    end

    // Drop happens only when full and nothing is leaving this cycle
    always_comb begin
        overflow_d = overflow_q | (push & fifo_full & ~(ev_valid & ev_ready));
    end

    always_ff @(posedge clock_fpga or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            skip_q     <= '0;
            tmo_q      <= '0;
            lshift_q   <= 1'b0;
            rshift_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            tmo_q      <= tmo_d;
            lshift_q   <= lshift_d;
            rshift_q   <= rshift_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_fpga (clock_fpga),
        .reset      (reset),
        .push       (push),
        .push_data  (push_ev),
        .pop_ready  (ev_ready),
        .out_valid  (ev_valid),
        .out_data   (head_ev),
        .count      (fifo_count),
        .full       (fifo_full)
    );

    assign ev_code    = head_ev.code;
    assign ev_ext     = head_ev.ext;
    assign ev_release = head_ev.rel;
    assign shift_held = lshift_q | rshift_q;
    assign overflow   = overflow_q;

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    logic       clock_fpga = 1'b0;
    logic       reset      = 1'b0;
    logic [7:0] code_in    = '0;
    logic       code_valid = 1'b0;
    logic       ev_ready   = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic       shift_held;
    logic       overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock_fpga = ~clock_fpga;

    ps2_key_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock_fpga (clock_fpga),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_release (ev_release),
        .shift_held (shift_held),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic send_byte(input logic [7:0] b);
        code_in    = b;
        code_valid = 1'b1;
        @(negedge clock_fpga);
        code_valid = 1'b0;
        code_in    = '0;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(negedge clock_fpga);
        ev_ready = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] c, input logic e, input logic r);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_code"},  32'(ev_code),  32'(c));
        check({tag, "_ext"},   32'(ev_ext),   32'(e));
        check({tag, "_rel"},   32'(ev_release), 32'(r));
        pop_one();
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && ev_valid; i++) begin
            pop_one();
        end
        check("drain_empty", 32'(ev_valid), 32'd0);
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_code",  32'(ev_code), 32'd0);
        check("rst_ext",   32'(ev_ext), 32'd0);
        check("rst_rel",   32'(ev_release), 32'd0);
        check("rst_shift", 32'(shift_held), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        @(negedge clock_fpga);
        reset = 1'b1;
        @(negedge clock_fpga);

        // Plain make code, latency 1
        send_byte(8'h1C);
        check("mk_count", 32'(fifo_count), 32'd1);
        expect_pop("mk", 8'h1C, 1'b0, 1'b0);
        check("mk_empty", 32'(ev_valid), 32'd0);

        // Extended break: no event for prefixes
        send_byte(8'hE0);
        check("e0_noev", 32'(ev_valid), 32'd0);
        send_byte(8'hF0);
        check("f0_noev", 32'(ev_valid), 32'd0);
        send_byte(8'h75);
        check("xb_count", 32'(fifo_count), 32'd1);
        expect_pop("xb", 8'h75, 1'b1, 1'b1);

        // Shift tracking
        send_byte(8'h12);
        check("lsh_make", 32'(shift_held), 32'd1);
        send_byte(8'hF0); send_byte(8'h12);
        check("lsh_brk", 32'(shift_held), 32'd0);
        send_byte(8'hE0); send_byte(8'h12);
        check("ext12", 32'(shift_held), 32'd0);
        send_byte(8'h59); send_byte(8'h12);
        send_byte(8'hF0); send_byte(8'h12);
        check("rsh_still", 32'(shift_held), 32'd1);
        send_byte(8'hF0); send_byte(8'h59);
        check("rsh_brk", 32'(shift_held), 32'd0);
        drain();

        // Overflow with stalled consumer
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  32'(overflow), 32'd1);
        repeat (2) @(negedge clock_fpga);
        check("hold_code", 32'(ev_code), 32'h01);
        for (int i = 1; i <= 4; i++) expect_pop("ovf_drain", 8'(i), 1'b0, 1'b0);
        check("ovf_empty", 32'(ev_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
        ev_ready = 1'b1;
        send_byte(8'h25);
        ev_ready = 1'b0;
        check("fullpp_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) expect_pop("fullpp", 8'h22 + 8'(i), 1'b0, 1'b0);

        // Push into empty while ready is high
        ev_ready = 1'b1;
        send_byte(8'h33);
        check("emptypp_valid", 32'(ev_valid), 32'd1);
        check("emptypp_count", 32'(fifo_count), 32'd1);
        check("emptypp_code",  32'(ev_code), 32'h33);
        @(negedge clock_fpga);
        ev_ready = 1'b0;
        check("emptypp_pop", 32'(ev_valid), 32'd0);

        // Timeout boundary: TIMEOUT-1 quiet cycles keeps the prefix
        send_byte(8'hE0);
        repeat (TIMEOUT - 1) @(negedge clock_fpga);
        send_byte(8'h1C);
        expect_pop("tmo_short", 8'h1C, 1'b1, 1'b0);
        // TIMEOUT quiet cycles abandons it
        send_byte(8'hE0);
        repeat (TIMEOUT) @(negedge clock_fpga);
        send_byte(8'h1C);
        expect_pop("tmo_full", 8'h1C, 1'b0, 1'b0);

        // Pause sequence
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        send_byte(8'h1C);
        check("pause_count", 32'(fifo_count), 32'd2);
        expect_pop("pause_e1", 8'hE1, 1'b0, 1'b0);
        expect_pop("pause_1c", 8'h1C, 1'b0, 1'b0);
        check("pause_empty", 32'(ev_valid), 32'd0);

        // Status byte cancels a prefix; E0 after F0 is discarded
        send_byte(8'hE0); send_byte(8'hAA);
        check("stat_noev", 32'(ev_valid), 32'd0);
        send_byte(8'h1C);
        expect_pop("stat", 8'h1C, 1'b0, 1'b0);
        send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h1C);
        check("f0f0_count", 32'(fifo_count), 32'd1);
        expect_pop("f0f0", 8'h1C, 1'b0, 1'b1);
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1C);
        check("f0e0_count", 32'(fifo_count), 32'd1);
        expect_pop("f0e0", 8'h1C, 1'b0, 1'b0);

        // Reset mid-sequence with a pending event and sticky overflow
        send_byte(8'h12);
        send_byte(8'hE0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_ovf",   32'(overflow), 32'd0);
        check("mid_rst_shift", 32'(shift_held), 32'd0);
        @(negedge clock_fpga);
        reset = 1'b1;
        @(negedge clock_fpga);
        send_byte(8'h1C);
        expect_pop("mid_rst", 8'h1C, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, prefix/skip abandon time in clock_fpga cycles (2 ms at 50 MHz).
REQ-003 SHALL have port clock_fpga  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port code_in  input  8  scan-code byte from the upstream PS/2 receiver.
REQ-006 SHALL have port code_valid  input  1  one-cycle strobe qualifying code_in.
REQ-007 SHALL have port ev_valid  output  1  FIFO head holds a key event.
REQ-008 SHALL have port ev_ready  input  1  consumer accepts the head event.
REQ-009 SHALL have port ev_code  output  8  head event key code.
REQ-010 SHALL have port ev_ext  output  1  head event had an E0 prefix.
REQ-011 SHALL have port ev_release  output  1  head event is a break (F0) event.
REQ-012 SHALL have port shift_held  output  1  left (0x12) or right (0x59) non-extended shift currently pressed.
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped because the FIFO was full.
REQ-014 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL run a prefix FSM with states IDLE, EXT, BRK, EXT_BRK and SKIP; bytes are acted on only in cycles with code_valid=1.
REQ-016 SHALL handle 0xE0: IDLE->EXT; EXT stays EXT; in BRK/EXT_BRK the byte is discarded and the FSM goes to IDLE.
REQ-017 SHALL handle 0xF0: IDLE->BRK; EXT->EXT_BRK; BRK/EXT_BRK stay unchanged.
REQ-018 SHALL handle any other byte in IDLE/EXT/BRK/EXT_BRK as follows: push event {code, ext=(EXT or EXT_BRK), release=(BRK or EXT_BRK)}, then go to IDLE.
REQ-019 SHALL discard the keyboard-status bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF with no event, forcing IDLE.
REQ-020 SHALL handle 0xE1 received in IDLE: push one event {0xE1, ext=0, release=0}, enter SKIP, and discard the next 7 bytes, then return to IDLE.
REQ-021 SHALL keep a timeout counter that clears on every code_valid and increments while in any state other than IDLE; on reaching TIMEOUT_CYCLES it SHALL force IDLE and clear the SKIP count, with no event.
REQ-022 SHALL update shift_held at event generation, independent of FIFO acceptance: set on non-extended make 0x12/0x59, cleared when neither is held; SHALL track each shift separately; extended 0x12 SHALL NOT affect it.
REQ-023 SHALL write an event into the FIFO on the clock edge that samples code_valid; if the FIFO was empty, ev_valid SHALL be 1 in the next cycle (latency 1).
REQ-024 SHALL pop the head on ev_valid&ev_ready; ev_code/ev_ext/ev_release SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-025 SHALL handle a push when full with no pop: drop the new event and set overflow; a simultaneous push and pop when full SHALL accept both, count unchanged.
REQ-026 SHALL accept a simultaneous push and pop when empty: ev_valid=1 next cycle, count 1.
REQ-027 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-028 SHALL, on reset=0 asynchronously, set FSM=IDLE, clear counters and FIFO, and drive ev_valid, ev_code, ev_ext, ev_release, shift_held, overflow, fifo_count to 0.
REQ-029 SHALL, after reset mid-sequence (e.g. after E0), decode the next byte as from IDLE; only reset SHALL clear overflow.

Structure
REQ-030 SHALL place in shared package ps2_pkg: constants for the E0/F0/E1/status codes and shift codes, and the key-event record type {code, ext, release}.
REQ-031 SHALL implement the FIFO as sub-module ps2_event_fifo (parameterised depth, valid/ready out, count, full).

Verification
REQ-032 SHALL verify: code 0x1C -> next cycle ev_valid=1, ev_code=0x1C, ext=0, release=0.
REQ-033 SHALL verify: E0,F0,0x75 -> single event 0x75, ext=1, release=1; no event for prefixes.
REQ-034 SHALL verify: 0x12 -> shift_held=1; F0,0x12 -> 0; E0,0x12 -> shift_held stays 0.
REQ-035 SHALL verify: with ev_ready=0, push 5 codes 0x01..0x05 (depth 4) -> fifo_count=4, overflow=1; draining yields 0x01..0x04 in order.
REQ-036 SHALL verify: E0, TIMEOUT_CYCLES idle cycles, then 0x1C -> event 0x1C, ext=0.
REQ-037 SHALL verify: E1,14,77,E1,F0,14,F0,77 then 0x1C -> exactly two events, 0xE1 then 0x1C.
